aes_enc_round_engine: RTL and testbench
=======================================

Name: aes_enc_round_engine

Overview:
Parametrised AES encryption round datapath supporting AES-128/192/256 (10/12/14 rounds), selected per operation. It substitutes SBOX_LANES 32-bit words per cycle through an external S-box bank. It sits between the key-expansion block, which supplies the round key indexed by the `round` output, and the top-level cipher wrapper. It adds per-operation key-length selection, configurable S-box parallelism and a completion pulse.

Parameters:
SBOX_LANES, 1, words substituted per SBOX cycle; legal values 1, 2 or 4 (other values are an elaboration error).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
next  input  1  start request; accepted only in IDLE.
keylen  input  2  0 = 10 rounds, 1 = 12 rounds, 2 = 14 rounds, 3 = treated as 10; sampled with `next`.
block  input  128  plaintext; used only in the INIT cycle.
round_key  input  128  key for the current `round`; combinationally consumed in INIT and MAIN.
round  output  4  current round counter.
sboxw  output  32*SBOX_LANES  words to the S-box; lane i is bits [32i+31:32i].
new_sboxw  input  32*SBOX_LANES  substituted words, same-cycle combinational return.
new_block  output  128  state register: {w0,w1,w2,w3}, w0 at [127:96].
ready  output  1  high when idle or result valid.
result_valid  output  1  one-cycle pulse when a ciphertext completes.

Behaviour:
- Reset values: state = 0, round = 0, ready = 1, result_valid = 0, FSM = IDLE, word counter = 0, nr_reg = 10.
- Reset asserted mid-operation aborts immediately to these values. No partial result is flagged.
- S = 4/SBOX_LANES is the number of SBOX cycles per round.
- IDLE, next = 1:
  - round <= 0, ready <= 0.
  - nr_reg <= 10/12/14 from keylen.
  - go to INIT.
  - next = 0 leaves all registers unchanged.
- INIT:
  - state <= block ^ round_key (round_key is the round-0 key).
  - round <= 1, word counter <= 0.
  - go to SBOX.
- SBOX:
  - Lane i presents word (ctr*SBOX_LANES + i) on sboxw.
  - new_sboxw lane i is written back to that word; other words hold.
  - ctr increments each cycle.
  - When ctr = S-1, go to MAIN; the counter wraps to 0.
- sboxw = 0 in every state other than SBOX.
- MAIN, round < nr_reg:
  - state <= MixColumns(ShiftRows(state)) ^ round_key.
  - round++, counter <= 0.
  - go to SBOX.
- MAIN, round = nr_reg (final round):
  - state <= ShiftRows(state) ^ round_key.
  - ready <= 1, result_valid <= 1 for one cycle.
  - go to IDLE. `round` holds nr_reg until the next start.
- Standard AES ShiftRows and MixColumns over GF(2^8), polynomial 0x11b; column-major bytes within each word, MSB byte is row 0.
- Latency: ready deasserts at the edge sampling next and reasserts exactly 1 + nr*(S+1) edges later.
  - SBOX_LANES = 1, nr = 10: 51 edges.
  - SBOX_LANES = 2, nr = 12: 37 edges.
  - SBOX_LANES = 4, nr = 14: 29 edges.
- `next` while busy is ignored, including in the final MAIN cycle.
- `next` in the first IDLE cycle after completion starts a new operation (back-to-back). new_block keeps the previous ciphertext until INIT overwrites it.
- keylen and block changes while busy have no effect. keylen is latched once per operation.
- new_block is valid ciphertext only while ready = 1 after a completed operation.

Test Plan:
- FIPS-197 C.1, SBOX_LANES = 1, keylen = 0: key 000102…0f, pt 00112233…eeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a; ready low 51 cycles; single result_valid pulse coincident with ready rise.
- FIPS-197 C.2, SBOX_LANES = 2, keylen = 1: key 000102…17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191; ready low 37 cycles; round sequence 0,1..12 observed.
- FIPS-197 C.3, SBOX_LANES = 4, keylen = 2: key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089; ready low 29 cycles; sboxw nonzero only in SBOX cycles.
- keylen = 3 with C.1 vector -> identical result and latency to keylen = 0. Toggling keylen/next/block while busy -> result unchanged, no restart.
- Back-to-back: next held high continuously -> second operation starts the cycle after ready rises. Two pulses on result_valid, spaced exactly latency + 1 cycles.
- Reset asserted at round 5, then released -> ready = 1, new_block = 0, round = 0, result_valid never pulses. A fresh C.1 run then passes.

Source files
------------

// File: rtl/aes_enc_round_engine.sv
// AES-128/192/256 encryption round datapath.
// S-box lookups go to an external bank, SBOX_LANES words per cycle.
module aes_enc_round_engine #(
  parameter int SBOX_LANES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    next,
  input  logic [1:0]              keylen,
  input  logic [127:0]            block,
  input  logic [127:0]            round_key,
  output logic [3:0]              round,
  output logic [32*SBOX_LANES-1:0] sboxw,
  input  logic [32*SBOX_LANES-1:0] new_sboxw,
  output logic [127:0]            new_block,
  output logic                    ready,
  output logic                    result_valid
);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  localparam int S  = 4 / SBOX_LANES;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t         fsm;
  logic [127:0]   state;
  logic [CW-1:0]  ctr;
  logic [3:0]     nr;
  int             base;
  logic [127:0]   sr;
  logic [127:0]   mc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Byte (row r, col c) lives at bit 127-8*(4c+r).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]),
            mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  assign base      = int'(ctr) * SBOX_LANES;
  assign sr        = shift_rows(state);
  assign mc        = mix_columns(sr);
  assign new_block = state;

  always_comb begin
    sboxw = '0;
    if (fsm == SBOX)
      for (int i = 0; i < SBOX_LANES; i++)
        sboxw[32*i +: 32] = state[(3-base-i)*32 +: 32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= IDLE;
      state        <= '0;
      round        <= '0;
      ctr          <= '0;
      nr           <= 4'd10;
      ready        <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (next) begin
            round <= '0;
            ready <= 1'b0;
            unique case (keylen)
              2'd1:    nr <= 4'd12;
              2'd2:    nr <= 4'd14;
              default: nr <= 4'd10;
            endcase
            fsm <= INIT;
          end
        end
        INIT: begin
          state <= block ^ round_key;
          round <= 4'd1;
          ctr   <= '0;
          fsm   <= SBOX;
        end
        SBOX: begin
          for (int i = 0; i < SBOX_LANES; i++)
            state[(3-base-i)*32 +: 32] <= new_sboxw[32*i +: 32];
          if (ctr == CW'(S-1)) begin
            ctr <= '0;
            fsm <= MAIN;
          end else begin
            ctr <= ctr + CW'(1);
          end
        end
        MAIN: begin
          // Final round skips MixColumns and leaves round at nr.
          if (round == nr) begin
            state        <= sr ^ round_key;
            ready        <= 1'b1;
            result_valid <= 1'b1;
            fsm          <= IDLE;
          end else begin
            state <= mc ^ round_key;
            round <= round + 4'd1;
            ctr   <= '0;
            fsm   <= SBOX;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Scoreboard bench: three engines (1/2/4 lanes) with a modelled
// S-box bank and key schedule, against FIPS-197 vectors.
module tb_aes_enc_round_engine;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]   keylen;
  logic [127:0] block;
  logic         nx  [3];
  logic         rdy [3];
  logic         rv  [3];
  logic [3:0]   rd  [3];
  logic [127:0] nb  [3];
  logic [127:0] rk  [3];
  logic [31:0]  sw1, nsw1;
  logic [63:0]  sw2, nsw2;
  logic [127:0] sw4, nsw4;

  int nk [3] = '{4, 4, 4};
  int lat [3];
  int cnt [3];
  int pulses [3];
  int prevp [3];
  int lastp [3];
  int cyc;
  int nz4;
  bit rec;
  logic [3:0]   rq [$];
  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  int n_chk;
  int n_pass;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r, p, v;
    logic [7:0] e;
    r = 8'h01; p = b; e = 8'd254;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = gmul(r, p);
      p = gmul(p, p);
    end
    v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
          ^ {r[3:0], r[7:4]} ^ 8'h63;
    return v;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] rkey(input logic [255:0] key,
                                        input int kn, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < kn; i++) w[i] = key[255-32*i -: 32];
    for (int i = kn; i < 60; i++) begin
      t = w[i-1];
      if (i % kn == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (kn > 6 && i % kn == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-kn] ^ t;
    end
    if (r < 0 || r > 14) return '0;
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int kn);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   b0, b1, b2, b3;
    logic [127:0] s;
    int nr;
    nr = kn + 6;
    s = pt ^ rkey(KEY, kn, 0);
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) a[k] = sbox(s[127-8*k -: 8]);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = a[4*((c+w)%4)+w];
      if (r < nr)
        for (int c = 0; c < 4; c++) begin
          b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
          t[4*c]   = gmul(8'h02, b0) ^ gmul(8'h03, b1) ^ b2 ^ b3;
          t[4*c+1] = b0 ^ gmul(8'h02, b1) ^ gmul(8'h03, b2) ^ b3;
          t[4*c+2] = b0 ^ b1 ^ gmul(8'h02, b2) ^ gmul(8'h03, b3);
          t[4*c+3] = gmul(8'h03, b0) ^ b1 ^ b2 ^ gmul(8'h02, b3);
        end
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = t[k];
      s = s ^ rkey(KEY, kn, r);
    end
    return s;
  endfunction

  always_comb begin
    rk[0] = rkey(KEY, nk[0], int'(rd[0]));
    rk[1] = rkey(KEY, nk[1], int'(rd[1]));
    rk[2] = rkey(KEY, nk[2], int'(rd[2]));
    nsw1  = sub_word(sw1);
    nsw2  = {sub_word(sw2[63:32]), sub_word(sw2[31:0])};
    nsw4  = {sub_word(sw4[127:96]), sub_word(sw4[95:64]),
             sub_word(sw4[63:32]), sub_word(sw4[31:0])};
  end

  aes_enc_round_engine #(.SBOX_LANES(1)) u1 (
    .clk(clk), .reset(reset), .next(nx[0]), .keylen(keylen),
    .block(block), .round_key(rk[0]), .round(rd[0]), .sboxw(sw1),
    .new_sboxw(nsw1), .new_block(nb[0]), .ready(rdy[0]),
    .result_valid(rv[0]));

  aes_enc_round_engine #(.SBOX_LANES(2)) u2 (
    .clk(clk), .reset(reset), .next(nx[1]), .keylen(keylen),
    .block(block), .round_key(rk[1]), .round(rd[1]), .sboxw(sw2),
    .new_sboxw(nsw2), .new_block(nb[1]), .ready(rdy[1]),
    .result_valid(rv[1]));

  aes_enc_round_engine #(.SBOX_LANES(4)) u4 (
    .clk(clk), .reset(reset), .next(nx[2]), .keylen(keylen),
    .block(block), .round_key(rk[2]), .round(rd[2]), .sboxw(sw4),
    .new_sboxw(nsw4), .new_block(nb[2]), .ready(rdy[2]),
    .result_valid(rv[2]));

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int id, input logic [127:0] v);
    case (id)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int id, output logic [127:0] v);
    case (id)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic qclr(input int id);
    case (id)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic mon(input int id);
    logic [127:0] e;
    if (!reset) begin
      cnt[id] = 0;
      return;
    end
    if (rv[id]) begin
      pulses[id]++;
      prevp[id] = lastp[id];
      lastp[id] = cyc;
      chk("ready_at_done", 128'(rdy[id]), 128'd1);
      chk("latency", 128'(cnt[id]), 128'(lat[id]));
      if (qsize(id) == 0) begin
        chk("unexpected_result", 128'd1, 128'd0);
      end else begin
        qpop(id, e);
        chk("result", nb[id], e);
      end
      cnt[id] = 0;
    end else if (!rdy[id]) begin
      cnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) mon(i);
    if (reset && rdy[2]) chk("sboxw_idle", sw4, 128'd0);
    if (reset && !rdy[2] && sw4 != '0) nz4++;
    if (rec && (rq.size() == 0 || rq[$] != rd[1])) rq.push_back(rd[1]);
  end

  function automatic int kl2nk(input logic [1:0] kl);
    return (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
  endfunction

  task automatic arm(input int id, input logic [1:0] kl, input logic [127:0] blk);
    keylen  = kl;
    block   = blk;
    nk[id]  = kl2nk(kl);
    lat[id] = 1 + (nk[id] + 6) * (4 / (1 << id) + 1);
    qpush(id, aes_ref(blk, nk[id]));
  endtask

  task automatic start(input int id, input logic [1:0] kl, input logic [127:0] blk);
    @(negedge clk);
    arm(id, kl, blk);
    nx[id] = 1'b1;
    @(negedge clk);
    nx[id] = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (qsize(id) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qsize(id) != 0) begin
      chk("timeout", 128'd0, 128'd1);
      qclr(id);
    end
    @(negedge clk);
  endtask

  initial begin
    int pc;
    int n;
    n_chk = 0; n_pass = 0; cyc = 0; nz4 = 0; rec = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nx[i] = 1'b0; cnt[i] = 0; pulses[i] = 0;
      prevp[i] = 0; lastp[i] = 0; lat[i] = 0;
    end
    keylen = 2'd0;
    block  = '0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(rdy[0]), 128'd1);
    chk("rst_valid", 128'(rv[0]), 128'd0);
    chk("rst_block", nb[0], 128'd0);
    chk("rst_round", 128'(rd[2]), 128'd0);

    start(0, 2'd0, PT);
    wait_done(0);
    chk("c1_fips", nb[0], C1);
    chk("c1_pulses", 128'(pulses[0]), 128'd1);

    rq.delete();
    rec = 1'b1;
    start(1, 2'd1, PT);
    wait_done(1);
    rec = 1'b0;
    chk("c2_fips", nb[1], C2);
    chk("c2_round_cnt", 128'(rq.size()), 128'd13);
    for (int i = 0; i < rq.size() && i < 13; i++)
      chk("c2_round_seq", 128'(rq[i]), 128'(i));

    nz4 = 0;
    start(2, 2'd2, PT);
    wait_done(2);
    chk("c3_fips", nb[2], C3);
    chk("c3_sbox_cycles", 128'(nz4), 128'd14);

    start(0, 2'd3, PT);
    wait_done(0);
    chk("kl3_result", nb[0], C1);

    pc = pulses[0];
    start(0, 2'd0, PT);
    @(negedge clk);
    repeat (20) begin
      keylen = 2'($urandom);
      block  = {$urandom, $urandom, $urandom, $urandom};
      nx[0]  = 1'($urandom);
      @(negedge clk);
    end
    nx[0] = 1'b0; keylen = 2'd0; block = PT;
    wait_done(0);
    chk("busy_toggle_result", nb[0], C1);
    chk("busy_toggle_pulses", 128'(pulses[0] - pc), 128'd1);

    pc = pulses[0];
    @(negedge clk);
    arm(0, 2'd0, PT);
    qpush(0, C1);
    nx[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv[0] && n < 300);
    @(negedge clk);
    nx[0] = 1'b0;
    chk("b2b_restart", 128'(rdy[0]), 128'd0);
    wait_done(0);
    chk("b2b_pulses", 128'(pulses[0] - pc), 128'd2);
    chk("b2b_spacing", 128'(lastp[0] - prevp[0]), 128'd52);
    chk("b2b_result", nb[0], C1);

    pc = pulses[0];
    start(0, 2'd0, PT);
    n = 0;
    while (rd[0] != 4'd5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_round5", 128'(rd[0]), 128'd5);
    reset = 1'b0;
    qclr(0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 128'(rdy[0]), 128'd1);
    chk("abort_block", nb[0], 128'd0);
    chk("abort_round", 128'(rd[0]), 128'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_pulse", 128'(pulses[0] - pc), 128'd0);

    start(0, 2'd0, PT);
    wait_done(0);
    chk("fresh_c1", nb[0], C1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
